// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stateful hazard controller for the 5-stage OTTER pipeline.
//   Forwarding selects are combinational. Load-use stalls, redirect flushes and
//   data-memory wait freezes are sequenced by a small FSM with a down-counter.
//   Control outputs are a function of the current state and the current hazard
//   inputs, so a hazard acts in the same cycle it appears.
//
// Ports:
//   CLK, RST                         clock (rising edge), async active-high reset
//   de_rs1/2, de_rs1/2_used          decode-stage sources
//   ex_rs1/2, ex_rs1/2_used          execute-stage sources
//   ex_rd, ex_memread                execute-stage destination / load flag
//   mem_rd, mem_regwrite             memory-stage destination / write flag
//   wb_rd, wb_regwrite               writeback-stage destination / write flag
//   pc_source                        nonzero = taken redirect resolved in execute
//   dmem_req, dmem_ready             data-memory handshake from the memory stage
//   fsel1, fsel2                     forwarding select: 00 regfile, 01 WB, 10 MEM
//   pc_write, if_de_write            PC and IF/DE register enables
//   if_de_flush, de_ex_bubble        IF/DE clear, DE/EX NOP insertion
//   pipe_freeze                      hold EX/MEM and MEM/WB
//   busy                             FSM not in RUN
//
// Optional build macro HAZARD_PERF_CNT_EN adds saturating 32-bit counters:
//   lu_stall_cnt (load-use bubble cycles), flush_cnt (if_de_flush cycles),
//   mem_wait_cnt (cycles spent in MEM_WAIT).

module pipeline_hazard_ctrl #(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned LU_STALL     = 1,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [REG_AW-1:0] de_rs1,
    input  logic [REG_AW-1:0] de_rs2,
    input  logic              de_rs1_used,
    input  logic              de_rs2_used,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic              ex_rs1_used,
    input  logic              ex_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic [1:0]        pc_source,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic [1:0]        fsel1,
    output logic [1:0]        fsel2,
    output logic              pc_write,
    output logic              if_de_write,
    output logic              if_de_flush,
    output logic              de_ex_bubble,
    output logic              pipe_freeze,
    output logic              busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       lu_stall_cnt,
    output logic [31:0]       flush_cnt,
    output logic [31:0]       mem_wait_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LU_RELOAD   = CNT_W'(LU_STALL - 1);
    localparam logic [CNT_W-1:0] FL_RELOAD   = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LU_STALL = 2'd1,
        S_FLUSH    = 2'd2,
        S_MEM_WAIT = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic lu;
    logic rd;
    logic mw;

    // Select MEM over WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              used,
        input logic [REG_AW-1:0] m_rd,
        input logic              m_we,
        input logic [REG_AW-1:0] w_rd,
        input logic              w_we
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used && m_we && (m_rd != '0) && (m_rd == rs)) begin
            sel = 2'b10;
        end else if (used && w_we && (w_rd != '0) && (w_rd == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Hazard conditions.
    always_comb begin
        lu = ex_memread && (ex_rd != '0) &&
             (((ex_rd == de_rs1) && de_rs1_used) || ((ex_rd == de_rs2) && de_rs2_used));
        rd = (pc_source != 2'b00);
        mw = dmem_req && !dmem_ready;
    end

    // Forwarding selects, forced to regfile while in reset.
    always_comb begin
        fsel1 = 2'b00;
        fsel2 = 2'b00;
        if (!RST) begin
            fsel1 = fwd_sel(ex_rs1, ex_rs1_used, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
            fsel2 = fwd_sel(ex_rs2, ex_rs2_used, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        end
    end

    // State and down-counter sequencing.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_RUN: begin
                    if (mw) begin
                        state <= S_MEM_WAIT;
                    end else if (rd) begin
                        if (FLUSH_CYCLES > 1) begin
                            state <= S_FLUSH;
                            cnt   <= FL_RELOAD;
                        end
                    end else if (lu) begin
                        if (LU_STALL > 1) begin
                            state <= S_LU_STALL;
                            cnt   <= LU_RELOAD;
                        end
                    end
                end
                S_LU_STALL: begin
                    // A memory wait cancels the rest of the stall.
                    if (mw) begin
                        state <= S_MEM_WAIT;
                        cnt   <= '0;
                    end else if (cnt == CNT_ONE) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_FLUSH: begin
                    // A fresh redirect restarts the flush window.
                    if (rd) begin
                        cnt <= FL_RELOAD;
                    end else if (cnt == CNT_ONE) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_MEM_WAIT: begin
                    if (dmem_ready) begin
                        state <= S_RUN;
                    end
                    cnt <= '0;
                end
                default: begin
                    state <= S_RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Pipeline control outputs for the current state and hazards.
    always_comb begin
        pc_write     = 1'b1;
        if_de_write  = 1'b1;
        if_de_flush  = 1'b0;
        de_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        busy         = 1'b0;
        if (RST) begin
            pc_write     = 1'b0;
            if_de_write  = 1'b0;
            if_de_flush  = 1'b1;
            de_ex_bubble = 1'b1;
        end else begin
            busy = (state != S_RUN);
            unique case (state)
                S_RUN: begin
                    if (mw) begin
                        pipe_freeze = 1'b1;
                        pc_write    = 1'b0;
                        if_de_write = 1'b0;
                    end else if (rd) begin
                        if_de_flush  = 1'b1;
                        de_ex_bubble = 1'b1;
                    end else if (lu) begin
                        pc_write     = 1'b0;
                        if_de_write  = 1'b0;
                        de_ex_bubble = 1'b1;
                    end
                end
                S_LU_STALL: begin
                    pc_write     = 1'b0;
                    if_de_write  = 1'b0;
                    de_ex_bubble = 1'b1;
                end
                S_FLUSH: begin
                    if_de_flush  = 1'b1;
                    de_ex_bubble = 1'b1;
                end
                S_MEM_WAIT: begin
                    // Back end resumes the cycle ready arrives; front end
                    // holds so pending hazards are re-evaluated in RUN.
                    pc_write    = 1'b0;
                    if_de_write = 1'b0;
                    pipe_freeze = !dmem_ready;
                end
                default: begin
                    pc_write    = 1'b0;
                    if_de_write = 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // A bubble without a flush can only come from a load-use stall.
    logic lu_bubble;
    assign lu_bubble = de_ex_bubble && !if_de_flush;

    // Saturating performance counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lu_stall_cnt <= '0;
            flush_cnt    <= '0;
            mem_wait_cnt <= '0;
        end else begin
            if (lu_bubble && (lu_stall_cnt != '1)) begin
                lu_stall_cnt <= lu_stall_cnt + 32'd1;
            end
            if (if_de_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
            if ((state == S_MEM_WAIT) && (mem_wait_cnt != '1)) begin
                mem_wait_cnt <= mem_wait_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Instance a: LU_STALL=2, FLUSH_CYCLES=3.
// Instance b: LU_STALL=3, FLUSH_CYCLES=3. Both share every input.
// Expected control word: {fsel1, fsel2, pc_write, if_de_write, if_de_flush,
// de_ex_bubble, pipe_freeze, busy}.

module tb_pipeline_hazard_ctrl;

    localparam int unsigned AW = 5;

    typedef struct packed {
        logic [AW-1:0] de_rs1;
        logic [AW-1:0] de_rs2;
        logic          de_rs1_used;
        logic          de_rs2_used;
        logic [AW-1:0] ex_rs1;
        logic [AW-1:0] ex_rs2;
        logic          ex_rs1_used;
        logic          ex_rs2_used;
        logic [AW-1:0] ex_rd;
        logic          ex_memread;
        logic [AW-1:0] mem_rd;
        logic          mem_regwrite;
        logic [AW-1:0] wb_rd;
        logic          wb_regwrite;
        logic [1:0]    pc_source;
        logic          dmem_req;
        logic          dmem_ready;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [9:0] exp;
    } vec_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW-1:0] de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          de_rs1_used, de_rs2_used, ex_rs1_used, ex_rs2_used;
    logic          ex_memread, mem_regwrite, wb_regwrite, dmem_req, dmem_ready;
    logic [1:0]    pc_source;

    logic [1:0] fsel1_a, fsel2_a, fsel1_b, fsel2_b;
    logic pc_write_a, if_de_write_a, if_de_flush_a, de_ex_bubble_a, pipe_freeze_a, busy_a;
    logic pc_write_b, if_de_write_b, if_de_flush_b, de_ex_bubble_b, pipe_freeze_b, busy_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_cnt_a, fl_cnt_a, mw_cnt_a, lu_cnt_b, fl_cnt_b, mw_cnt_b;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.REG_AW(AW), .LU_STALL(2), .FLUSH_CYCLES(3), .CNT_W(3)) dut_a (
        .CLK(CLK), .RST(RST),
        .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .pc_source(pc_source),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .fsel1(fsel1_a), .fsel2(fsel2_a), .pc_write(pc_write_a), .if_de_write(if_de_write_a),
        .if_de_flush(if_de_flush_a), .de_ex_bubble(de_ex_bubble_a),
        .pipe_freeze(pipe_freeze_a), .busy(busy_a)
`ifdef HAZARD_PERF_CNT_EN
        , .lu_stall_cnt(lu_cnt_a), .flush_cnt(fl_cnt_a), .mem_wait_cnt(mw_cnt_a)
`endif
    );

    pipeline_hazard_ctrl #(.REG_AW(AW), .LU_STALL(3), .FLUSH_CYCLES(3), .CNT_W(3)) dut_b (
        .CLK(CLK), .RST(RST),
        .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .pc_source(pc_source),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .fsel1(fsel1_b), .fsel2(fsel2_b), .pc_write(pc_write_b), .if_de_write(if_de_write_b),
        .if_de_flush(if_de_flush_b), .de_ex_bubble(de_ex_bubble_b),
        .pipe_freeze(pipe_freeze_b), .busy(busy_b)
`ifdef HAZARD_PERF_CNT_EN
        , .lu_stall_cnt(lu_cnt_b), .flush_cnt(fl_cnt_b), .mem_wait_cnt(mw_cnt_b)
`endif
    );

    logic [9:0] act_a, act_b;
    assign act_a = {fsel1_a, fsel2_a, pc_write_a, if_de_write_a, if_de_flush_a,
                    de_ex_bubble_a, pipe_freeze_a, busy_a};
    assign act_b = {fsel1_b, fsel2_b, pc_write_b, if_de_write_b, if_de_flush_b,
                    de_ex_bubble_b, pipe_freeze_b, busy_b};

    function automatic logic [9:0] e(input logic [1:0] f1, input logic [1:0] f2,
                                     input logic pcw, input logic ifw, input logic fl,
                                     input logic bub, input logic frz, input logic bsy);
        return {f1, f2, pcw, ifw, fl, bub, frz, bsy};
    endfunction

    function automatic in_t idle();
        in_t t;
        t = '0;
        return t;
    endfunction

    function automatic in_t fw(input logic [AW-1:0] r1, input logic u1,
                               input logic [AW-1:0] r2, input logic u2,
                               input logic [AW-1:0] mrd, input logic mwe,
                               input logic [AW-1:0] wrd, input logic wwe);
        in_t t;
        t = '0;
        t.ex_rs1 = r1; t.ex_rs1_used = u1;
        t.ex_rs2 = r2; t.ex_rs2_used = u2;
        t.mem_rd = mrd; t.mem_regwrite = mwe;
        t.wb_rd = wrd; t.wb_regwrite = wwe;
        return t;
    endfunction

    function automatic in_t ld(input logic mr, input logic [AW-1:0] rd,
                               input logic [AW-1:0] s1, input logic u1,
                               input logic [AW-1:0] s2, input logic u2);
        in_t t;
        t = '0;
        t.ex_memread = mr; t.ex_rd = rd;
        t.de_rs1 = s1; t.de_rs1_used = u1;
        t.de_rs2 = s2; t.de_rs2_used = u2;
        return t;
    endfunction

    function automatic in_t redir(input logic [1:0] ps);
        in_t t;
        t = '0;
        t.pc_source = ps;
        return t;
    endfunction

    function automatic in_t mem(input logic req, input logic rdy);
        in_t t;
        t = '0;
        t.dmem_req = req;
        t.dmem_ready = rdy;
        return t;
    endfunction

    task automatic drive(input in_t t);
        de_rs1 = t.de_rs1; de_rs2 = t.de_rs2;
        de_rs1_used = t.de_rs1_used; de_rs2_used = t.de_rs2_used;
        ex_rs1 = t.ex_rs1; ex_rs2 = t.ex_rs2;
        ex_rs1_used = t.ex_rs1_used; ex_rs2_used = t.ex_rs2_used;
        ex_rd = t.ex_rd; ex_memread = t.ex_memread;
        mem_rd = t.mem_rd; mem_regwrite = t.mem_regwrite;
        wb_rd = t.wb_rd; wb_regwrite = t.wb_regwrite;
        pc_source = t.pc_source;
        dmem_req = t.dmem_req; dmem_ready = t.dmem_ready;
    endtask

    // Apply inputs after the falling edge and sample midway to the next rising edge.
    task automatic cyc(input in_t t);
        @(negedge CLK);
        drive(t);
        #2;
    endtask

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    vec_t tbl[13];
    logic [9:0] run_idle;
    in_t t;

    initial begin
        run_idle = e(2'b00, 2'b00, 1, 1, 0, 0, 0, 0);

        tbl[0]  = '{"fwd_mem_beats_wb",   fw(0,0, 7,1, 7,1, 7,1), e(2'b00,2'b10,1,1,0,0,0,0)};
        tbl[1]  = '{"fwd_wb_mem_x0",      fw(0,0, 7,1, 0,1, 7,1), e(2'b00,2'b01,1,1,0,0,0,0)};
        tbl[2]  = '{"fwd_rs2_unused",     fw(0,0, 7,0, 7,1, 7,1), e(2'b00,2'b00,1,1,0,0,0,0)};
        tbl[3]  = '{"fwd_wb_mem_nowrite", fw(3,1, 0,0, 3,0, 3,1), e(2'b01,2'b00,1,1,0,0,0,0)};
        tbl[4]  = '{"fwd_both_mem",       fw(4,1, 4,1, 4,1, 9,1), e(2'b10,2'b10,1,1,0,0,0,0)};
        tbl[5]  = '{"fwd_x0_never",       fw(0,1, 0,1, 0,1, 0,1), e(2'b00,2'b00,1,1,0,0,0,0)};
        tbl[6]  = '{"fwd_split",          fw(6,1, 8,1, 8,1, 6,1), e(2'b01,2'b10,1,1,0,0,0,0)};
        tbl[7]  = '{"fwd_no_match",       fw(6,1, 0,0, 5,1, 6,0), e(2'b00,2'b00,1,1,0,0,0,0)};
        tbl[8]  = '{"fwd_rs1_unused",     fw(9,0, 9,1, 9,1, 0,0), e(2'b00,2'b10,1,1,0,0,0,0)};
        tbl[9]  = '{"lu_src_unused",      ld(1,5, 5,0, 5,0),      run_idle};
        tbl[10] = '{"lu_rd_x0",           ld(1,0, 0,1, 0,1),      run_idle};
        tbl[11] = '{"lu_not_load",        ld(0,5, 5,1, 5,1),      run_idle};
        tbl[12] = '{"mw_ready_same",      mem(1,1),               run_idle};

        // Reset: outputs forced even with a forwarding match present.
        RST = 1'b1;
        drive(fw(0,0, 7,1, 7,1, 7,1));
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #2;
        chk("reset_a", act_a, e(2'b00,2'b00,0,0,1,1,0,0));
        chk("reset_b", act_b, e(2'b00,2'b00,0,0,1,1,0,0));
        RST = 1'b0;
        drive(idle());
        #1;
        chk("post_reset_idle", act_a, run_idle);

        // Load-use with LU_STALL=2.
        cyc(ld(1,5, 5,1, 0,0)); chk("lu_c0", act_a, e(2'b00,2'b00,0,0,0,1,0,0));
        cyc(idle());            chk("lu_c1", act_a, e(2'b00,2'b00,0,0,0,1,0,1));
        cyc(idle());            chk("lu_c2", act_a, run_idle);

        // One-cycle redirect with FLUSH_CYCLES=3.
        cyc(redir(2'b01)); chk("fl_c0", act_a, e(2'b00,2'b00,1,1,1,1,0,0));
        cyc(idle());       chk("fl_c1", act_a, e(2'b00,2'b00,1,1,1,1,0,1));
        cyc(idle());       chk("fl_c2", act_a, e(2'b00,2'b00,1,1,1,1,0,1));
        cyc(idle());       chk("fl_c3", act_a, run_idle);
`ifdef HAZARD_PERF_CNT_EN
        chk32("perf_lu_a", lu_cnt_a, 32'd2);
        chk32("perf_fl_a", fl_cnt_a, 32'd3);
        chk32("perf_mw_a", mw_cnt_a, 32'd0);
        chk32("perf_lu_b", lu_cnt_b, 32'd3);
`endif

        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].in);
            chk(tbl[i].name, act_a, tbl[i].exp);
        end

        // Memory wait masks simultaneous load-use and redirect.
        t = ld(1,5, 5,1, 0,0);
        t.pc_source = 2'b10;
        t.dmem_req = 1'b1;
        t.dmem_ready = 1'b0;
        cyc(t); chk("mw_c0", act_a, e(2'b00,2'b00,0,0,0,0,1,0));
        for (int i = 1; i < 4; i++) begin
            cyc(t); chk("mw_hold", act_a, e(2'b00,2'b00,0,0,0,0,1,1));
        end
        t.dmem_ready = 1'b1;
        cyc(t); chk("mw_ready", act_a, e(2'b00,2'b00,0,0,0,0,0,1));
        t.dmem_req = 1'b0;
        t.dmem_ready = 1'b0;
        cyc(t); chk("mw_rd_after", act_a, e(2'b00,2'b00,1,1,1,1,0,0));
        cyc(idle()); chk("mw_fl1", act_a, e(2'b00,2'b00,1,1,1,1,0,1));
`ifdef HAZARD_PERF_CNT_EN
        chk32("perf_mw_a4", mw_cnt_a, 32'd4);
`endif
        cyc(idle()); chk("mw_fl2", act_a, e(2'b00,2'b00,1,1,1,1,0,1));
        cyc(idle()); chk("mw_run", act_a, run_idle);

        // Redirect during FLUSH restarts the window.
        cyc(redir(2'b11)); chk("rl_c0", act_a, e(2'b00,2'b00,1,1,1,1,0,0));
        cyc(redir(2'b01)); chk("rl_c1", act_a, e(2'b00,2'b00,1,1,1,1,0,1));
        cyc(idle());       chk("rl_c2", act_a, e(2'b00,2'b00,1,1,1,1,0,1));
        cyc(idle());       chk("rl_c3", act_a, e(2'b00,2'b00,1,1,1,1,0,1));
        cyc(idle());       chk("rl_c4", act_a, run_idle);

        // Load-use on rs2, then memory wait preempts the stall.
        cyc(ld(1,9, 0,0, 9,1)); chk("pre_c0", act_a, e(2'b00,2'b00,0,0,0,1,0,0));
        cyc(mem(1,0));          chk("pre_c1", act_a, e(2'b00,2'b00,0,0,0,1,0,1));
        cyc(mem(1,1));          chk("pre_c2_a", act_a, e(2'b00,2'b00,0,0,0,0,0,1));
                                chk("pre_c2_b", act_b, e(2'b00,2'b00,0,0,0,0,0,1));
        cyc(idle());            chk("pre_c3_a", act_a, run_idle);
                                chk("pre_c3_b", act_b, run_idle);

        // Async reset during the 2nd cycle of a 3-cycle stall (instance b).
        cyc(ld(1,5, 5,1, 0,0)); chk("rst_c0_b", act_b, e(2'b00,2'b00,0,0,0,1,0,0));
        cyc(idle());            chk("rst_c1_b", act_b, e(2'b00,2'b00,0,0,0,1,0,1));
        RST = 1'b1;
        #1;
        chk("rst_mid_b", act_b, e(2'b00,2'b00,0,0,1,1,0,0));
        RST = 1'b0;
        #1;
        chk("rst_rel_b", act_b, run_idle);
        chk("rst_rel_a", act_a, run_idle);
`ifdef HAZARD_PERF_CNT_EN
        chk32("perf_clr_lu_a", lu_cnt_a, 32'd0);
        chk32("perf_clr_fl_a", fl_cnt_a, 32'd0);
`endif
        cyc(idle()); chk("rst_run_b", act_b, run_idle);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
